dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave answering one request at a time after
// a fixed number of wait cycles, with byte-lane writes and address wrap.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   i_dmem_addr    byte address of the request
//   i_dmem_ren     read request
//   i_dmem_wen     write request (wins over ren)
//   i_dmem_mask    byte-lane write enable
//   i_dmem_wdata   write data
//   o_dmem_busy    high while an access is in flight
//   o_dmem_rvalid  one-cycle read-data-valid pulse
//   o_dmem_rdata   registered read data, held until the next read response
//   o_dmem_wack    one-cycle write-complete pulse
//   o_dmem_err     one-cycle error pulse with rvalid/wack
// Parameters: DEPTH_WORDS (power of two, 16..65536), LATENCY (0..15).
// Option macro DMEM_MISALIGN_CHECK_EN: flag addr[1:0]!=0 with err,
// suppress the write and return zero read data.

module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [3:0]  i_dmem_mask,
   input  logic [31:0] i_dmem_wdata,
   output logic        o_dmem_busy,
   output logic        o_dmem_rvalid,
   output logic [31:0] o_dmem_rdata,
   output logic        o_dmem_wack,
   output logic        o_dmem_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 =
      (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic          w_accept;

   logic [AW+1:0] r_addr;
   logic [3:0]    r_mask;
   logic [31:0]   r_wdata;
   logic          r_wr;
   logic [31:0]   r_rdata;

   logic [31:0]   r_mem [DEPTH_WORDS];

   logic [AW+1:0] w_src_addr;
   logic          w_src_wr;
   logic          w_src_mis;
   logic          w_cap_mis;
   logic          w_rd_load;
   logic [31:0]   w_rd_word;
   logic          w_mem_we;
   logic          w_unused;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_dmem_ren || i_dmem_wen) begin
               w_accept = 1'b1;
               if (LATENCY > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = LAT_M1;
               end else begin
                  w_state_nxt = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Read-data source. With LATENCY=0 the RESP state is entered on the
   // accepting edge itself, so the word must come from the live request
   // rather than the capture registers.
   // ------------------------------------------------------------------
   always_comb begin
      w_src_addr = r_addr;
      w_src_wr   = r_wr;
      if (r_state == S_IDLE) begin
         w_src_addr = i_dmem_addr[AW+1:0];
         w_src_wr   = i_dmem_wen;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_src_mis = |w_src_addr[1:0];
   assign w_cap_mis = |r_addr[1:0];
`else
   assign w_src_mis = 1'b0;
   assign w_cap_mis = 1'b0;
`endif

   assign w_rd_word = r_mem[w_src_addr[AW+1:2]];
   assign w_rd_load = (r_state != S_RESP)
                   && (w_state_nxt == S_RESP)
                   && !w_src_wr;

   // ------------------------------------------------------------------
   // State, counter, capture and read-data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_mask  <= 4'd0;
         r_wdata <= 32'd0;
         r_wr    <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_addr  <= i_dmem_addr[AW+1:0];
            r_mask  <= i_dmem_mask;
            r_wdata <= i_dmem_wdata;
            r_wr    <= i_dmem_wen;
         end
         if (w_rd_load) begin
            r_rdata <= w_src_mis ? 32'd0 : w_rd_word;
         end
      end
   end

   // ------------------------------------------------------------------
   // Storage: never reset; the write lands on the edge that ends RESP,
   // and a reset on that edge cancels it.
   // ------------------------------------------------------------------
   assign w_mem_we = rst
                  && (r_state == S_RESP)
                  && r_wr
                  && !w_cap_mis;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (r_mask[b]) begin
               r_mem[r_addr[AW+1:2]][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_dmem_busy   = (r_state != S_IDLE);
   assign o_dmem_rvalid = (r_state == S_RESP) && !r_wr;
   assign o_dmem_wack   = (r_state == S_RESP) && r_wr;
   assign o_dmem_err    = (r_state == S_RESP) && w_cap_mis;
   assign o_dmem_rdata  = r_rdata;

   // Address bits above the word index wrap away; the byte offset only
   // matters when the misalignment check is built in.
   assign w_unused = ^{i_dmem_addr[31:AW+2], w_src_addr[1:0], r_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
// Hand-computed expected values; one checking task counts every compare.

module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] i_dmem_addr;
   logic        i_dmem_ren;
   logic        i_dmem_wen;
   logic [3:0]  i_dmem_mask;
   logic [31:0] i_dmem_wdata;
   logic        o_dmem_busy;
   logic        o_dmem_rvalid;
   logic [31:0] o_dmem_rdata;
   logic        o_dmem_wack;
   logic        o_dmem_err;

   int n_chk;
   int n_err;

   dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_dmem_addr  (i_dmem_addr),
      .i_dmem_ren   (i_dmem_ren),
      .i_dmem_wen   (i_dmem_wen),
      .i_dmem_mask  (i_dmem_mask),
      .i_dmem_wdata (i_dmem_wdata),
      .o_dmem_busy  (o_dmem_busy),
      .o_dmem_rvalid(o_dmem_rvalid),
      .o_dmem_rdata (o_dmem_rdata),
      .o_dmem_wack  (o_dmem_wack),
      .o_dmem_err   (o_dmem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // One request; returns edge count (accepting edge = 1) at which the
   // response was seen, plus the response signals. Returns in IDLE.
   task automatic xact(input  logic        wen,
                       input  logic        ren,
                       input  logic [31:0] a,
                       input  logic [3:0]  m,
                       input  logic [31:0] d,
                       output int          n,
                       output logic        rv,
                       output logic        wk,
                       output logic        er,
                       output logic [31:0] rd);
      @(negedge clk);
      i_dmem_addr  = a;
      i_dmem_wen   = wen;
      i_dmem_ren   = ren;
      i_dmem_mask  = m;
      i_dmem_wdata = d;
      @(posedge clk);
      #1;
      i_dmem_wen = 1'b0;
      i_dmem_ren = 1'b0;
      n = 1;
      while (!(o_dmem_rvalid || o_dmem_wack) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      rv = o_dmem_rvalid;
      wk = o_dmem_wack;
      er = o_dmem_err;
      rd = o_dmem_rdata;
      @(posedge clk);
      #1;
   endtask

   int          n;
   logic        rv;
   logic        wk;
   logic        er;
   logic [31:0] rd;
   int          pulses;
   int          pos1;
   int          pos2;

   initial begin
      n_chk        = 0;
      n_err        = 0;
      rst          = 1'b0;
      i_dmem_addr  = 32'd0;
      i_dmem_ren   = 1'b0;
      i_dmem_wen   = 1'b0;
      i_dmem_mask  = 4'd0;
      i_dmem_wdata = 32'd0;

      // Reset sequence
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy",   32'(o_dmem_busy),   32'd0);
      chk("rst_rvalid", 32'(o_dmem_rvalid), 32'd0);
      chk("rst_wack",   32'(o_dmem_wack),   32'd0);
      chk("rst_err",    32'(o_dmem_err),    32'd0);
      chk("rst_rdata",  o_dmem_rdata,       32'd0);

      // Full-word write then read, latency check
      xact(1, 0, 32'h10, 4'hF, 32'hDEADBEEF, n, rv, wk, er, rd);
      chk("wr10_edges", 32'(n),  32'd3);
      chk("wr10_wack",  32'(wk), 32'd1);
      chk("wr10_rv",    32'(rv), 32'd0);
      chk("wr10_err",   32'(er), 32'd0);
      chk("wack_pulse", 32'(o_dmem_wack), 32'd0);
      xact(0, 1, 32'h10, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("rd10_edges", 32'(n),  32'd3);
      chk("rd10_rv",    32'(rv), 32'd1);
      chk("rd10_data",  rd,      32'hDEADBEEF);
      chk("rv_pulse",   32'(o_dmem_rvalid), 32'd0);

      // Byte-lane mask
      xact(1, 0, 32'h20, 4'hF, 32'h11223344, n, rv, wk, er, rd);
      xact(1, 0, 32'h20, 4'h5, 32'hAABBCCDD, n, rv, wk, er, rd);
      chk("mask_wack", 32'(wk), 32'd1);
      xact(0, 1, 32'h20, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("mask_data", rd, 32'h11BB33DD);

      // Address wrap-around
      xact(1, 0, 32'h1000, 4'hF, 32'h5A5A5A5A, n, rv, wk, er, rd);
      xact(0, 1, 32'h0000, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("wrap_data", rd, 32'h5A5A5A5A);

      // Empty mask still acks, storage untouched; rdata held across write
      xact(1, 0, 32'h10, 4'h0, 32'hFFFFFFFF, n, rv, wk, er, rd);
      chk("m0_wack", 32'(wk), 32'd1);
      chk("rd_hold", rd, 32'h5A5A5A5A);
      xact(0, 1, 32'h10, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("m0_data", rd, 32'hDEADBEEF);

      // ren held high: requests while busy ignored, RESP never
      // accepts back-to-back; second read accepted at edge 5
      @(negedge clk);
      i_dmem_addr = 32'h0;
      i_dmem_ren  = 1'b1;
      pulses = 0;
      pos1   = 0;
      pos2   = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) begin
            i_dmem_addr = 32'h10;
         end
         if (k == 5) begin
            i_dmem_ren = 1'b0;
         end
         if (o_dmem_rvalid) begin
            pulses++;
            if (pos1 == 0) pos1 = k;
            else if (pos2 == 0) pos2 = k;
         end
         if (k == 3) begin
            chk("busy_rdata", o_dmem_rdata, 32'h5A5A5A5A);
         end
      end
      chk("busy_pulses", 32'(pulses), 32'd2);
      chk("busy_pos1",   32'(pos1),   32'd3);
      chk("busy_pos2",   32'(pos2),   32'd7);
      chk("busy_rd2",    o_dmem_rdata, 32'hDEADBEEF);

      // ren=wen=1 acts as a write
      xact(1, 1, 32'h40, 4'hF, 32'h12345678, n, rv, wk, er, rd);
      chk("both_wack", 32'(wk), 32'd1);
      chk("both_rv",   32'(rv), 32'd0);
      xact(0, 1, 32'h40, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("both_data", rd, 32'h12345678);

      // Reset during WAIT aborts the write
      @(negedge clk);
      i_dmem_addr  = 32'h10;
      i_dmem_wen   = 1'b1;
      i_dmem_mask  = 4'hF;
      i_dmem_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      i_dmem_wen = 1'b0;
      chk("wait_busy", 32'(o_dmem_busy), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy",  32'(o_dmem_busy),  32'd0);
      chk("abort_rdata", o_dmem_rdata,      32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (o_dmem_wack || o_dmem_rvalid) pulses++;
      end
      chk("abort_pulse", 32'(pulses), 32'd0);
      xact(0, 1, 32'h10, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("abort_data", rd, 32'hDEADBEEF);

      // Misaligned access
      xact(1, 0, 32'h22, 4'hF, 32'hA5A5A5A5, n, rv, wk, er, rd);
      chk("mis_wack", 32'(wk), 32'd1);
`ifdef DMEM_MISALIGN_CHECK_EN
      chk("mis_err", 32'(er), 32'd1);
      xact(0, 1, 32'h20, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("mis_store", rd, 32'h11BB33DD);
      xact(0, 1, 32'h21, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("mis_rerr", 32'(er), 32'd1);
      chk("mis_rzero", rd, 32'd0);
`else
      chk("mis_err", 32'(er), 32'd0);
      xact(0, 1, 32'h20, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("mis_store", rd, 32'hA5A5A5A5);
      xact(0, 1, 32'h21, 4'h0, 32'h0, n, rv, wk, er, rd);
      chk("mis_rerr", 32'(er), 32'd0);
      chk("mis_rdata", rd, 32'hA5A5A5A5);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
